wb_stage: RTL and testbench

WB_STAGE -- requirements
Module: wb_stage

---
 rtl/wb_stage_if.sv | 27 ++
 rtl/wb_stage.sv | 127 ++++++++++++
 tb/tb_wb_stage.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_stage_if.sv
// Pipeline bus between MEM and WB: instruction fields in, register-file write port and status out.
interface wb_stage_if;
    logic        in_valid;
    logic [31:0] in_pc;
    logic [4:0]  in_rd;
    logic        in_rf_we;
    logic [1:0]  in_wb_sel;
    logic [31:0] in_alu;
    logic [31:0] in_mem_rdata;
    logic [2:0]  in_funct3;

    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;
    logic        wb_valid;
    logic [31:0] wb_pc;

    modport master (
        output in_valid, in_pc, in_rd, in_rf_we, in_wb_sel, in_alu, in_mem_rdata, in_funct3,
        input  rf_we, rf_wa, rf_wd, wb_valid, wb_pc
    );

    modport slave (
        input  in_valid, in_pc, in_rd, in_rf_we, in_wb_sel, in_alu, in_mem_rdata, in_funct3,
        output rf_we, rf_wa, rf_wd, wb_valid, wb_pc
    );
endinterface

// File: rtl/wb_stage.sv
// Write-back stage: one pipeline register, load extraction and register-file write port.
// Optional retired-instruction counter enabled by defining WB_RETIRE_CNT_EN.
module wb_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    wb_stage_if.slave   bus
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [31:0] retire_cnt
`endif
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned RW   = 5;

    logic            valid_q, valid_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [RW-1:0]   rd_q, rd_d;
    logic            we_q, we_d;
    logic [1:0]      sel_q, sel_d;
    logic [XLEN-1:0] alu_q, alu_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic [2:0]      f3_q, f3_d;

    // Flush only kills the valid bit; stall holds everything.
    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        rd_d    = rd_q;
        we_d    = we_q;
        sel_d   = sel_q;
        alu_d   = alu_q;
        rdata_d = rdata_q;
        f3_d    = f3_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (!stall) begin
            valid_d = bus.in_valid;
            pc_d    = bus.in_pc;
            rd_d    = bus.in_rd;
            we_d    = bus.in_rf_we;
            sel_d   = bus.in_wb_sel;
            alu_d   = bus.in_alu;
            rdata_d = bus.in_mem_rdata;
            f3_d    = bus.in_funct3;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            rd_q    <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            alu_q   <= '0;
            rdata_q <= '0;
            f3_q    <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            rd_q    <= rd_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            alu_q   <= alu_d;
            rdata_q <= rdata_d;
            f3_q    <= f3_d;
        end
    end

    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [XLEN-1:0] ld_data;
    logic [XLEN-1:0] wd;

    // Halfword selection ignores offset bit 0; word loads ignore the offset entirely.
    always_comb begin
        ld_byte = rdata_q[{alu_q[1:0], 3'b000} +: 8];
        ld_half = alu_q[1] ? rdata_q[31:16] : rdata_q[15:0];
        case (f3_q)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_data = {24'h000000, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_data = {16'h0000, ld_half};
            default: ld_data = rdata_q;
        endcase
    end

    always_comb begin
        case (sel_q)
            2'b01:   wd = ld_data;
            2'b10:   wd = pc_q + XLEN'(4);
            default: wd = alu_q;
        endcase
    end

    assign bus.rf_we    = valid_q & we_q & (rd_q != '0);
    assign bus.rf_wa    = rd_q;
    assign bus.rf_wd    = wd;
    assign bus.wb_valid = valid_q;
    assign bus.wb_pc    = pc_q;

`ifdef WB_RETIRE_CNT_EN
    logic [XLEN-1:0] retire_q, retire_d;

    // An instruction retires when it leaves WB without being held; wraps naturally.
    always_comb begin
        retire_d = retire_q;
        if (valid_q && (!stall || flush)) begin
            retire_d = retire_q + XLEN'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            retire_q <= '0;
        end else begin
            retire_q <= retire_d;
        end
    end

    assign retire_cnt = retire_q;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios plus randomized traffic against a reference model.
module tb_wb_stage;

    logic clk = 1'b0;
    logic rst;
    logic stall;
    logic flush;

    wb_stage_if bus ();

`ifdef WB_RETIRE_CNT_EN
    logic [31:0] retire_cnt;
`endif

    wb_stage dut (
        .clk   (clk),
        .rst   (rst),
        .stall (stall),
        .flush (flush),
        .bus   (bus.slave)
`ifdef WB_RETIRE_CNT_EN
        ,
        .retire_cnt (retire_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        we;
        logic [1:0]  sel;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [2:0]  f3;
    } ent_t;

    ent_t        nxt;
    ent_t        m;
    logic [31:0] exp_cnt;
    int          total = 0;
    int          bad   = 0;

    // Reference load extraction: shift the word down by the byte offset, then trim and extend.
    function automatic logic [31:0] ref_load(input ent_t e);
        logic [7:0]  b;
        logic [15:0] h;
        int unsigned off;
        off = int'(e.alu[1:0]);
        b = 8'(e.rdata >> (8 * off));
        h = 16'(e.rdata >> (16 * (off / 2)));
        case (e.f3)
            3'd0:    return 32'($signed(b));
            3'd4:    return 32'(b);
            3'd1:    return 32'($signed(h));
            3'd5:    return 32'(h);
            default: return e.rdata;
        endcase
    endfunction

    function automatic logic [31:0] ref_wd(input ent_t e);
        if (e.sel == 2'd1) return ref_load(e);
        if (e.sel == 2'd2) return 32'((64'(e.pc) + 64'd4) % 64'h1_0000_0000);
        return e.alu;
    endfunction

    function automatic logic ref_we(input ent_t e);
        return e.valid && e.we && (e.rd != 5'd0);
    endfunction

    task automatic drive(input logic v, input logic [31:0] pc, input logic [4:0] rd, input logic we,
                         input logic [1:0] sel, input logic [31:0] alu, input logic [31:0] rdata,
                         input logic [2:0] f3);
        nxt = '{v, pc, rd, we, sel, alu, rdata, f3};
        bus.in_valid     = v;
        bus.in_pc        = pc;
        bus.in_rd        = rd;
        bus.in_rf_we     = we;
        bus.in_wb_sel    = sel;
        bus.in_alu       = alu;
        bus.in_mem_rdata = rdata;
        bus.in_funct3    = f3;
    endtask

    // Apply controls, take one edge, advance the model, sample 1ns after the edge.
    task automatic tick(input logic r, input logic f, input logic s);
        rst   = r;
        flush = f;
        stall = s;
        @(posedge clk);
        if (r) begin
            m       = '0;
            exp_cnt = '0;
        end else if (f) begin
            if (m.valid) exp_cnt = exp_cnt + 32'd1;
            m.valid = 1'b0;
        end else if (!s) begin
            if (m.valid) exp_cnt = exp_cnt + 32'd1;
            m = nxt;
        end
        #1;
    endtask

    task automatic test_reset();
        drive(1'b1, 32'h100, 5'd7, 1'b1, 2'd0, 32'hABCD, 32'h0, 3'd0);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        total++; if (bus.rf_we !== 1'b0) begin bad++; $display("FAIL reset_rf_we got=%0b want=0", bus.rf_we); end
        total++; if (bus.rf_wa !== 5'd0) begin bad++; $display("FAIL reset_rf_wa got=%0d want=0", bus.rf_wa); end
        total++; if (bus.wb_valid !== 1'b0) begin bad++; $display("FAIL reset_wb_valid got=%0b want=0", bus.wb_valid); end
`ifdef WB_RETIRE_CNT_EN
        total++; if (retire_cnt !== 32'd0) begin bad++; $display("FAIL reset_cnt got=%h want=0", retire_cnt); end
`endif
    endtask

    task automatic test_alu();
        drive(1'b1, 32'h200, 5'd5, 1'b1, 2'd0, 32'h1234, 32'hDEAD_BEEF, 3'd2);
        tick(1'b0, 1'b0, 1'b0);
        total++; if (bus.rf_we !== 1'b1) begin bad++; $display("FAIL alu_rf_we got=%0b want=1", bus.rf_we); end
        total++; if (bus.rf_wa !== 5'd5) begin bad++; $display("FAIL alu_rf_wa got=%0d want=5", bus.rf_wa); end
        total++; if (bus.rf_wd !== 32'h0000_1234) begin bad++; $display("FAIL alu_rf_wd got=%h want=00001234", bus.rf_wd); end
        total++; if (bus.wb_pc !== 32'h200) begin bad++; $display("FAIL alu_wb_pc got=%h want=00000200", bus.wb_pc); end
    endtask

    task automatic test_loads();
        logic [2:0]  f3s [4] = '{3'd0, 3'd4, 3'd1, 3'd5};
        logic [31:0] alus[4] = '{32'h1003, 32'h2002, 32'h3002, 32'h4001};
        logic [31:0] want[4] = '{32'hFFFF_FF80, 32'h0000_00FF, 32'hFFFF_80FF, 32'h0000_0011};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h300, 5'd9, 1'b1, 2'd1, alus[i], 32'h80FF_0011, f3s[i]);
            tick(1'b0, 1'b0, 1'b0);
            total++;
            if (bus.rf_wd !== want[i]) begin
                bad++; $display("FAIL load_%0d got=%h want=%h", i, bus.rf_wd, want[i]);
            end
        end
        drive(1'b1, 32'h300, 5'd9, 1'b1, 2'd1, 32'h3, 32'h80FF_0011, 3'd2);
        tick(1'b0, 1'b0, 1'b0);
        total++; if (bus.rf_wd !== 32'h80FF_0011) begin bad++; $display("FAIL load_lw got=%h want=80ff0011", bus.rf_wd); end
    endtask

    task automatic test_pc4_rd0();
        drive(1'b1, 32'hFFFF_FFFC, 5'd3, 1'b1, 2'd2, 32'h55, 32'h0, 3'd0);
        tick(1'b0, 1'b0, 1'b0);
        total++; if (bus.rf_wd !== 32'h0) begin bad++; $display("FAIL pc4_wrap got=%h want=00000000", bus.rf_wd); end
        drive(1'b1, 32'h400, 5'd0, 1'b1, 2'd0, 32'h77, 32'h0, 3'd0);
        tick(1'b0, 1'b0, 1'b0);
        total++; if (bus.rf_we !== 1'b0) begin bad++; $display("FAIL rd0_we got=%0b want=0", bus.rf_we); end
        drive(1'b1, 32'h404, 5'd4, 1'b1, 2'd3, 32'h99, 32'h0, 3'd0);
        tick(1'b0, 1'b0, 1'b0);
        total++; if (bus.rf_wd !== 32'h99) begin bad++; $display("FAIL sel11 got=%h want=00000099", bus.rf_wd); end
    endtask

    task automatic test_stall();
        logic [31:0] c0;
        drive(1'b1, 32'h500, 5'd12, 1'b1, 2'd0, 32'hA0A0_0001, 32'h0, 3'd0);
        tick(1'b0, 1'b0, 1'b0);
        c0 = exp_cnt;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h600 + 32'(i), 5'd20 + 5'(i), 1'b1, 2'd2, $urandom, $urandom, 3'd0);
            tick(1'b0, 1'b0, 1'b1);
            total++;
            if (bus.rf_we !== 1'b1 || bus.rf_wa !== 5'd12 || bus.rf_wd !== 32'hA0A0_0001) begin
                bad++; $display("FAIL stall_hold_%0d got=%0b/%0d/%h want=1/12/a0a00001", i, bus.rf_we, bus.rf_wa, bus.rf_wd);
            end
`ifdef WB_RETIRE_CNT_EN
            total++; if (retire_cnt !== c0) begin bad++; $display("FAIL stall_cnt_%0d got=%h want=%h", i, retire_cnt, c0); end
`endif
        end
        drive(1'b1, 32'h700, 5'd13, 1'b1, 2'd0, 32'hB0B0_0002, 32'h0, 3'd0);
        tick(1'b0, 1'b0, 1'b0);
        total++; if (bus.rf_wa !== 5'd13 || bus.rf_wd !== 32'hB0B0_0002) begin bad++; $display("FAIL stall_release got=%0d/%h want=13/b0b00002", bus.rf_wa, bus.rf_wd); end
`ifdef WB_RETIRE_CNT_EN
        total++; if (retire_cnt !== c0 + 32'd1) begin bad++; $display("FAIL stall_release_cnt got=%h want=%h", retire_cnt, c0 + 32'd1); end
`endif
    endtask

    task automatic test_flush_rst();
        logic [31:0] c0;
        c0 = exp_cnt;
        tick(1'b0, 1'b1, 1'b1);
        total++; if (bus.wb_valid !== 1'b0 || bus.rf_we !== 1'b0) begin bad++; $display("FAIL flush_stall got=%0b/%0b want=0/0", bus.wb_valid, bus.rf_we); end
`ifdef WB_RETIRE_CNT_EN
        total++; if (retire_cnt !== c0 + 32'd1) begin bad++; $display("FAIL flush_cnt got=%h want=%h", retire_cnt, c0 + 32'd1); end
`endif
        drive(1'b1, 32'h800, 5'd14, 1'b1, 2'd0, 32'h1, 32'h0, 3'd0);
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b1, 1'b0, 1'b1);
        total++; if (bus.wb_valid !== 1'b0 || bus.rf_wa !== 5'd0) begin bad++; $display("FAIL rst_stall got=%0b/%0d want=0/0", bus.wb_valid, bus.rf_wa); end
`ifdef WB_RETIRE_CNT_EN
        total++; if (retire_cnt !== 32'd0) begin bad++; $display("FAIL rst_stall_cnt got=%h want=0", retire_cnt); end
`endif
    endtask

`ifdef WB_RETIRE_CNT_EN
    task automatic test_wrap();
        drive(1'b1, 32'h900, 5'd15, 1'b1, 2'd0, 32'h2, 32'h0, 3'd0);
        tick(1'b0, 1'b0, 1'b0);
        force dut.retire_q = 32'hFFFF_FFFF;
        tick(1'b0, 1'b0, 1'b1);
        release dut.retire_q;
        exp_cnt = 32'hFFFF_FFFF;
        total++; if (retire_cnt !== 32'hFFFF_FFFF) begin bad++; $display("FAIL wrap_preload got=%h want=ffffffff", retire_cnt); end
        tick(1'b0, 1'b0, 1'b0);
        total++; if (retire_cnt !== 32'h0) begin bad++; $display("FAIL wrap got=%h want=00000000", retire_cnt); end
    endtask
`endif

    task automatic test_random();
        logic r, f, s;
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom), $urandom, 5'($urandom_range(0, 31)), 1'($urandom), 2'($urandom),
                  $urandom, $urandom, 3'($urandom));
            r = ($urandom_range(0, 29) == 0);
            f = ($urandom_range(0, 7) == 0);
            s = ($urandom_range(0, 3) == 0);
            tick(r, f, s);
            total++;
            if (bus.wb_valid !== m.valid || bus.rf_we !== ref_we(m) || bus.rf_wa !== m.rd) begin
                bad++; $display("FAIL rand_ctl_%0d got=%0b/%0b/%0d want=%0b/%0b/%0d", i, bus.wb_valid, bus.rf_we, bus.rf_wa, m.valid, ref_we(m), m.rd);
            end
            total++;
            if (bus.rf_wd !== ref_wd(m) || bus.wb_pc !== m.pc) begin
                bad++; $display("FAIL rand_data_%0d got=%h/%h want=%h/%h", i, bus.rf_wd, bus.wb_pc, ref_wd(m), m.pc);
            end
`ifdef WB_RETIRE_CNT_EN
            total++; if (retire_cnt !== exp_cnt) begin bad++; $display("FAIL rand_cnt_%0d got=%h want=%h", i, retire_cnt, exp_cnt); end
`endif
        end
    endtask

    initial begin
        m       = '0;
        exp_cnt = '0;
        rst     = 1'b1;
        flush   = 1'b0;
        stall   = 1'b0;
        drive(1'b0, '0, '0, 1'b0, '0, '0, '0, '0);
        #1;
        test_reset();
        test_alu();
        test_loads();
        test_pc4_rd0();
        test_stall();
        test_flush_rst();
`ifdef WB_RETIRE_CNT_EN
        test_wrap();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
